pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Input-capture receiver for PWM waveforms: the measuring end of the pwmchannel output link.
- Samples an asynchronous PWM input, detects edges, and reports the period and high-time of every full cycle in clk cycles.
- Used for loopback checking of pwmchannel and for measuring external PWM sources.
- Measurement convention matches pwmchannel. A generator programmed with period P, duty D, left-aligned, polarity 0 is reported as period_out=P, duty_out=D.

Parameters:
- CNT_WIDTH, 32, width of the counter and of the period/duty results.
- SYNC_STAGES, 2, number of synchronizer flops on pwm_in (minimum 2).
- FILTER_LEN, 4, cycles of stable input needed to accept a level; used only with the optional feature.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- pwm_in  in  1  asynchronous PWM input
- enable  in  1  capture enable, level-sensitive
- polarity  in  1  1 = invert pwm_in after synchronization, so the low phase is measured as duty
- clear  in  1  single-cycle pulse: clears results and overflow, restarts capture
- period_out  out  CNT_WIDTH  last measured period in clk cycles
- duty_out  out  CNT_WIDTH  last measured active time in clk cycles
- meas_valid  out  1  one-cycle pulse when period_out and duty_out update
- overflow  out  1  sticky flag: counter saturated with no edge
- busy  out  1  high in ARM, HIGH and LOW states

Behaviour:
- Interface: one clock clk; reset n_rst is asynchronous, active-low.
- Reset values:
  - Synchronizer, edge register and counter = 0.
  - FSM = IDLE.
  - period_out=0, duty_out=0, meas_valid=0, overflow=0, busy=0.
- Input conditioning:
  - lvl = (last synchronizer stage) XOR polarity.
  - prev = lvl delayed by one cycle.
  - rise = lvl & ~prev; fall = ~lvl & prev.
- FSM states: IDLE, ARM, HIGH, LOW.
  - enable=0 in any state: go to IDLE next cycle. Results and overflow hold; no meas_valid.
  - IDLE, enable=1: go to ARM. The first partial cycle is never reported.
  - ARM, rise: cnt<=1, go to HIGH.
  - HIGH: cnt increments each cycle. On fall: duty_cap<=cnt, cnt increments, go to LOW.
  - LOW: cnt increments each cycle. On rise: period_out<=cnt, duty_out<=duty_cap, meas_valid=1 for one cycle, cnt<=1, go to HIGH.
  - Measurements are back-to-back: every subsequent rise yields a new result.
- Counter semantics: cnt=1 in the cycle after a rise detect. Therefore high time D gives duty_cap=D, and period P gives period_out=P.
- Latency: meas_valid asserts on the (SYNC_STAGES+1)th posedge after the pwm_in rising edge that ends the period.
- Saturation: cnt stops at all-ones. Reaching all-ones in HIGH or LOW with no edge causes:
  - overflow<=1 (sticky),
  - go to ARM,
  - the partial measurement is discarded.
- clear:
  - period_out<=0, duty_out<=0, overflow<=0.
  - FSM goes to ARM if enable=1, else IDLE.
  - clear wins over a coincident edge, meas_valid or overflow event.
- A rise and a fall cannot occur in the same cycle. meas_valid and overflow setting are mutually exclusive.
- Reset asserted mid-measurement: immediate return to reset values; nothing is reported.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A glitch filter sits between the synchronizer and the polarity XOR.
  - The filtered level changes only after the raw synchronized level has differed from it for FILTER_LEN consecutive cycles.
  - Both edges see the same delay, so pulses ≥FILTER_LEN cycles are measured exactly.
  - Shorter pulses are suppressed.
  - Latency grows by FILTER_LEN cycles.
- Undefined: no filter; behaviour as above.

Decomposition:
- Shared package pwm_capture_pkg:
  - FSM state typedef (IDLE, ARM, HIGH, LOW), 2-bit encoding.
  - Default width constants shared with pwmchannel (32-bit period/duty).
- Sub-module pwm_input_conditioner: synchronizer, optional filter, polarity XOR and edge detector. Outputs lvl, rise, fall.
- The FSM and counter stay in pwm_capture.

Test Plan:
- Drive pwmchannel (period=10, duty=3, enable, left-aligned) into pwm_in, enable=1 → from the second full period onward, meas_valid pulses every 10 cycles with period_out=10, duty_out=3.
- Same stimulus with polarity=1 → period_out=10, duty_out=7.
- CNT_WIDTH=8, pwm_in held at 1 after one rise → overflow=1 after 255 cycles, FSM in ARM, period_out unchanged. A clear pulse → overflow=0, outputs=0.
- Deassert enable mid-HIGH → busy=0 next cycle, no meas_valid, outputs hold. Re-enable → first result arrives only after two rises.
- Change the generator from period=10/duty=3 to 20/15 → results go 10/3 then 20/15 with no mixed value.
- With PWM_CAPTURE_FILTER_EN and FILTER_LEN=4, add 2-cycle glitches inside the low phase of a 10/3 waveform → results stay 10/3. Without the macro → spurious short results appear.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture receiver: FSM state encoding and
// default widths that match the pwmchannel generator.
package pwm_capture_pkg;

    localparam int PWM_CNT_WIDTH   = 32;
    localparam int PWM_SYNC_STAGES = 2;
    localparam int PWM_FILTER_LEN  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } capState_t;

endpackage

// File: rtl/pwm_input_conditioner.sv
// Synchronizes the asynchronous PWM input, applies polarity and detects edges.
// Defining PWM_CAPTURE_FILTER_EN inserts a FILTER_LEN-cycle glitch filter before the polarity XOR.
module pwm_input_conditioner
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = PWM_SYNC_STAGES,
    parameter int FILTER_LEN  = PWM_FILTER_LEN
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_pwm,
    input  logic i_polarity,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_raw;
    logic                   w_clean;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
        end
    end

    assign w_raw = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic          r_filt;
    logic [FW-1:0] r_filtCnt;

    // The accepted level only follows the raw level after FILTER_LEN consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_filt    <= 1'b0;
            r_filtCnt <= '0;
        end else if (w_raw == r_filt) begin
            r_filtCnt <= '0;
        end else if (r_filtCnt == FW'(FILTER_LEN - 1)) begin
            r_filt    <= w_raw;
            r_filtCnt <= '0;
        end else begin
            r_filtCnt <= r_filtCnt + 1'b1;
        end
    end

    assign w_clean = r_filt;
`else
    assign w_clean = w_raw;
`endif

    assign o_lvl = w_clean ^ i_polarity;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= o_lvl;
        end
    end

    assign o_rise = o_lvl & ~r_prev;
    assign o_fall = ~o_lvl & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM input-capture receiver: measures period and active time of every full
// PWM cycle in clk cycles, with sticky overflow on counter saturation.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_WIDTH   = PWM_CNT_WIDTH,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES,
    parameter int FILTER_LEN  = PWM_FILTER_LEN
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 pwm_in,
    input  logic                 enable,
    input  logic                 polarity,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] duty_out,
    output logic                 meas_valid,
    output logic                 overflow,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic w_lvl;
    logic w_rise;
    logic w_fall;

    capState_t            r_state, w_stateNext;
    logic [CNT_WIDTH-1:0] r_cnt, w_cntNext;
    logic [CNT_WIDTH-1:0] r_dutyCap, w_dutyCapNext;
    logic [CNT_WIDTH-1:0] r_period, w_periodNext;
    logic [CNT_WIDTH-1:0] r_duty, w_dutyNext;
    logic                 r_valid, w_validNext;
    logic                 r_overflow, w_overflowNext;
    logic [CNT_WIDTH-1:0] w_cntInc;

    pwm_input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_cond (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_pwm     (pwm_in),
        .i_polarity(polarity),
        .o_lvl     (w_lvl),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dutyCap  <= '0;
            r_period   <= '0;
            r_duty     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_dutyCap  <= w_dutyCapNext;
            r_period   <= w_periodNext;
            r_duty     <= w_dutyNext;
            r_valid    <= w_validNext;
            r_overflow <= w_overflowNext;
        end
    end

    assign w_cntInc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // clear outranks everything, then enable; edges outrank saturation inside a measurement.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_dutyCapNext  = r_dutyCap;
        w_periodNext   = r_period;
        w_dutyNext     = r_duty;
        w_validNext    = 1'b0;
        w_overflowNext = r_overflow;

        if (clear) begin
            w_periodNext   = '0;
            w_dutyNext     = '0;
            w_overflowNext = 1'b0;
            w_stateNext    = enable ? S_ARM : S_IDLE;
        end else if (!enable) begin
            w_stateNext = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_stateNext = S_ARM;
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_cntNext   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        w_stateNext = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        w_dutyCapNext = r_cnt;
                        w_cntNext     = w_cntInc;
                        w_stateNext   = S_LOW;
                    end else if ((r_cnt == CNT_MAX) && w_lvl) begin
                        w_overflowNext = 1'b1;
                        w_stateNext    = S_ARM;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        w_periodNext = r_cnt;
                        w_dutyNext   = r_dutyCap;
                        w_validNext  = 1'b1;
                        w_cntNext    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        w_stateNext  = S_HIGH;
                    end else if ((r_cnt == CNT_MAX) && !w_lvl) begin
                        w_overflowNext = 1'b1;
                        w_stateNext    = S_ARM;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end
                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end
    end

    assign period_out = r_period;
    assign duty_out   = r_duty;
    assign meas_valid = r_valid;
    assign overflow   = r_overflow;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: drives PWM trains and compares every reported
// measurement against a rise-to-rise reference computed from the driven waveform.
module tb_pwm_capture;

    localparam int CW = 8;

    logic          clk      = 1'b0;
    logic          n_rst    = 1'b0;
    logic          pwm_in   = 1'b0;
    logic          enable   = 1'b0;
    logic          polarity = 1'b0;
    logic          clear    = 1'b0;
    logic [CW-1:0] period_out;
    logic [CW-1:0] duty_out;
    logic          meas_valid;
    logic          overflow;
    logic          busy;

    int assertCount = 0;
    int failCount   = 0;

    bit wave[$];
    int gotPeriod[$];
    int gotDuty[$];
    int expPeriod[$];
    int expDuty[$];

    pwm_capture #(
        .CNT_WIDTH  (CW),
        .SYNC_STAGES(2),
        .FILTER_LEN (4)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pwm_in    (pwm_in),
        .enable    (enable),
        .polarity  (polarity),
        .clear     (clear),
        .period_out(period_out),
        .duty_out  (duty_out),
        .meas_valid(meas_valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Collect every reported result, sampled away from the active edge.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            gotPeriod.push_back(int'(period_out));
            gotDuty.push_back(int'(duty_out));
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Hold pwm_in at level v for n clock cycles, recording the waveform.
    task automatic applyStimulus(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = v;
            wave.push_back(v);
        end
    endtask

    task automatic pulses(input int h, input int l, input int n);
        repeat (n) begin
            applyStimulus(1'b1, h);
            applyStimulus(1'b0, l);
        end
    endtask

    // Reference: every pair of consecutive active-level rises is one result;
    // period is the rise spacing, duty the active cycles between them.
    function automatic void buildModel(input bit pol);
        bit lv[$];
        int rises[$];
        int hi;
        expPeriod.delete();
        expDuty.delete();
        foreach (wave[i]) lv.push_back(wave[i] ^ pol);
        for (int i = 1; i < lv.size(); i++) begin
            if (lv[i] && !lv[i-1]) rises.push_back(i);
        end
        for (int k = 0; k + 1 < rises.size(); k++) begin
            hi = 0;
            for (int j = rises[k]; j < rises[k+1]; j++) begin
                if (lv[j]) hi++;
            end
            expPeriod.push_back(rises[k+1] - rises[k]);
            expDuty.push_back(hi);
        end
    endfunction

    task automatic startPhase(input bit pol);
        @(negedge clk);
        enable   = 1'b0;
        polarity = pol;
        pwm_in   = pol;
        repeat (10) @(negedge clk);
        wave.delete();
        gotPeriod.delete();
        gotDuty.delete();
        enable = 1'b1;
        applyStimulus(pol, 6);
    endtask

    task automatic endPhase(input string tag, input bit pol);
        applyStimulus(wave[wave.size()-1], 12);
        buildModel(pol);
        checkOutput({tag, "_count"}, gotPeriod.size(), expPeriod.size());
        for (int i = 0; i < expPeriod.size() && i < gotPeriod.size(); i++) begin
            checkOutput($sformatf("%s_period%0d", tag, i), gotPeriod[i], expPeriod[i]);
            checkOutput($sformatf("%s_duty%0d", tag, i), gotDuty[i], expDuty[i]);
        end
    endtask

    initial begin
        bit rpol;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("rst_period", period_out, 0);
        checkOutput("rst_duty", duty_out, 0);
        checkOutput("rst_valid", meas_valid, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        $display("[TB] 10/3 train with latency probe");
        startPhase(1'b0);
        checkOutput("A_busy_armed", busy, 1);
        pulses(3, 7, 5);
        applyStimulus(1'b1, 1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus((k < 3) ? 1'b1 : 1'b0, 1);
            checkOutput($sformatf("A_latency%0d", k), meas_valid, (k == 3) ? 1 : 0);
        end
        applyStimulus(1'b0, 6);
        pulses(3, 7, 1);
        endPhase("A", 1'b0);
        checkOutput("A_period_out", period_out, 10);
        checkOutput("A_duty_out", duty_out, 3);

        $display("[TB] 10/3 train inverted polarity");
        startPhase(1'b1);
        pulses(3, 7, 6);
        endPhase("B", 1'b1);
        checkOutput("B_duty_out", duty_out, 7);

        $display("[TB] period change 10/3 to 20/15");
        startPhase(1'b0);
        pulses(3, 7, 4);
        pulses(15, 5, 4);
        endPhase("C", 1'b0);
        checkOutput("C_period_out", period_out, 20);
        checkOutput("C_duty_out", duty_out, 15);

        $display("[TB] random trains");
        for (int r = 0; r < 3; r++) begin
            rpol = 1'($urandom_range(1, 0));
            startPhase(rpol);
            for (int p = 0; p < 12; p++) begin
                pulses(int'($urandom_range(20, 1)), int'($urandom_range(20, 1)), 1);
            end
            endPhase($sformatf("R%0d", r), rpol);
        end

        $display("[TB] glitches in the low phase");
        startPhase(1'b0);
        for (int g = 0; g < 5; g++) begin
            applyStimulus(1'b1, 3);
            applyStimulus(1'b0, 3);
            applyStimulus(1'b1, 2);
            applyStimulus(1'b0, 2);
        end
        endPhase("G", 1'b0);

        $display("[TB] enable dropped mid-high");
        startPhase(1'b0);
        pulses(3, 7, 3);
        applyStimulus(1'b1, 4);
        checkOutput("E_busy_in_high", busy, 1);
        enable = 1'b0;
        applyStimulus(1'b1, 1);
        checkOutput("E_busy_after_disable", busy, 0);
        applyStimulus(1'b0, 7);
        pulses(3, 7, 2);
        applyStimulus(1'b0, 10);
        checkOutput("E_result_count_held", gotPeriod.size(), 3);
        checkOutput("E_period_held", period_out, 10);
        checkOutput("E_duty_held", duty_out, 3);
        startPhase(1'b0);
        pulses(3, 7, 1);
        applyStimulus(1'b0, 10);
        checkOutput("E_one_rise_no_result", gotPeriod.size(), 0);
        pulses(4, 6, 3);
        endPhase("E", 1'b0);

        $display("[TB] counter saturation and clear");
        startPhase(1'b0);
        pulses(3, 7, 2);
        applyStimulus(1'b1, 258);
        checkOutput("F_overflow_before", overflow, 0);
        applyStimulus(1'b1, 1);
        checkOutput("F_overflow_set", overflow, 1);
        checkOutput("F_busy_armed", busy, 1);
        checkOutput("F_period_kept", period_out, 10);
        checkOutput("F_duty_kept", duty_out, 3);
        checkOutput("F_result_count", gotPeriod.size(), 2);
        clear = 1'b1;
        applyStimulus(1'b1, 1);
        clear = 1'b0;
        checkOutput("F_clear_overflow", overflow, 0);
        checkOutput("F_clear_period", period_out, 0);
        checkOutput("F_clear_duty", duty_out, 0);
        checkOutput("F_clear_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
